mult_div_engine: RTL and testbench
==================================

Name: mult_div_engine

Overview:
- Iterative multiply/divide responder driven by the multicycle CPU control unit.
- CPU presents operands and an op code with a one-cycle start. Engine runs a 32-iteration radix-2 sequence, then returns HI/LO with a done pulse.
- Holds results until the next accepted operation. Flags divide-by-zero for the exception path.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_in  input  WIDTH  operand A (multiplicand / dividend), sampled only on accepted start
- b_in  input  WIDTH  operand B (multiplier / divisor), sampled only on accepted start
- op  input  3  3'b001 MULT, 3'b010 DIV, 3'b101 MULTU, 3'b110 DIVU; other codes are no-op
- start  input  1  request strobe, one cycle
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when HI/LO updated or div-by-zero reported
- hi_out  output  WIDTH  MULT upper product / DIV remainder
- lo_out  output  WIDTH  MULT lower product / DIV quotient
- div_zero  output  1  one-cycle pulse, coincident with done, on divide by zero

Behaviour:
- Reset: state IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0; iteration counter=0. Reset wins over every other event, including mid-operation; partial results are discarded.
- States: IDLE, MULT, DIV, FINISH.
- Accept rule: start is accepted only when busy=0, including the cycle in which done=1, and only for a valid op. Start with busy=1, or with an invalid op, is ignored with no side effects.
- On the accepting edge: latch a_in and b_in; clear counter; enter MULT or DIV; busy=1 from the next cycle.
- MULT: signed Booth radix-2. One iteration per cycle over 2*WIDTH+1-bit product register; 32 iterations, then FINISH.
- DIV: restoring division on magnitudes, 32 iterations, then FINISH.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign of dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0 (no trap).
- FINISH (single cycle): write hi_out and lo_out, done=1, busy=0, then return to IDLE.
- Latency: start accepted at edge N → done high in the cycle after edge N+33; busy high after edges N+1..N+32.
- Divide by zero (b=0, DIV or DIVU): no iterations. Edge N+1 gives done=1 and div_zero=1 for one cycle, busy stays 0, hi_out and lo_out unchanged.
- hi_out and lo_out hold their value between operations and change only in FINISH or on reset.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro MULT_DIV_UNSIGNED_EN.
- Defined: op[2]=1 selects unsigned mode.
  - MULTU uses zero-extended operands (shift-add).
  - DIVU uses no sign correction.
  - Latency and handshake are identical to signed ops.
- Undefined: op[2] ignored; 3'b101 and 3'b110 behave exactly as MULT and DIV.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) → exactly 33 cycles after accept: done=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy=0 in the done cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), div_zero=0.
- After a completed op, DIV a=5, b=0 → next cycle done=1 and div_zero=1, both for one cycle; hi_out and lo_out keep their prior values; busy never asserts.
- DIV a=0x80000000, b=0xFFFFFFFF → lo_out=0x80000000, hi_out=0.
- Start MULT 3×4. Pulse start with DIV 9/3 at iteration 5 → ignored, result hi=0, lo=12. Start MULT again, assert reset at iteration 10 → next cycle all outputs 0 and state IDLE. Then MULT 2×2 → lo_out=4.
- MULTU a=0xFFFFFFFF, b=2:
  - With MULT_DIV_UNSIGNED_EN → hi_out=0x00000001, lo_out=0xFFFFFFFE.
  - Without → hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_engine_if.sv
// Request/response bundle between the CPU control unit and mult_div_engine.
// The master drives operands, op and start; the slave returns busy/done, HI/LO and div_zero.
interface mult_div_engine_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output a_in, b_in, op, start,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  a_in, b_in, op, start,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_engine.sv
// Iterative radix-2 multiply/divide engine: signed Booth multiply, restoring divide on magnitudes.
// Optional MULT_DIV_UNSIGNED_EN: op[2] selects unsigned MULTU/DIVU; otherwise op[2] is ignored.
module mult_div_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_engine_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
`ifdef MULT_DIV_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1_reg;
    logic             uns_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             zero_div_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             op_valid;
    logic             op_div;
    logic             op_uns;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_rem;
    logic             div_fits;

    assign op_valid = (bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10);
    assign op_div   = (bus.op[1:0] == 2'b10);
    assign op_uns   = UNS_EN && bus.op[2];
    assign a_neg    = !op_uns && bus.a_in[WIDTH-1];
    assign b_neg    = !op_uns && bus.b_in[WIDTH-1];
    assign a_mag    = a_neg ? ({WIDTH{1'b0}} - bus.a_in) : bus.a_in;
    assign b_mag    = b_neg ? ({WIDTH{1'b0}} - bus.b_in) : bus.b_in;

    // The sum is one bit wider than the accumulator so the most negative
    // multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        acc_ext = uns_reg ? {1'b0, acc_reg} : {acc_reg[WIDTH-1], acc_reg};
        m_ext   = uns_reg ? {1'b0, m_reg}   : {m_reg[WIDTH-1], m_reg};
        mul_sum = acc_ext;
        if (uns_reg) begin
            if (q_reg[0]) begin
                mul_sum = acc_ext + m_ext;
            end
        end else begin
            case ({q_reg[0], q_m1_reg})
                2'b01:   mul_sum = acc_ext + m_ext;
                2'b10:   mul_sum = acc_ext - m_ext;
                default: mul_sum = acc_ext;
            endcase
        end
    end

    // Partial remainder is always below the divisor, so its low bits are exact.
    assign div_shift = {acc_reg, q_reg[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, m_reg});
    assign div_rem   = div_shift[WIDTH-1:0] - m_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            m_reg        <= '0;
            acc_reg      <= '0;
            q_reg        <= '0;
            q_m1_reg     <= 1'b0;
            uns_reg      <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_div_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start && op_valid) begin
                        cnt_reg  <= '0;
                        acc_reg  <= '0;
                        q_m1_reg <= 1'b0;
                        uns_reg  <= op_uns;
                        if (op_div) begin
                            m_reg        <= b_mag;
                            q_reg        <= a_mag;
                            neg_q_reg    <= a_neg ^ b_neg;
                            neg_r_reg    <= a_neg;
                            zero_div_reg <= (bus.b_in == '0);
                            state_reg    <= (bus.b_in == '0) ? FINISH : DIV;
                        end else begin
                            m_reg        <= bus.a_in;
                            q_reg        <= bus.b_in;
                            neg_q_reg    <= 1'b0;
                            neg_r_reg    <= 1'b0;
                            zero_div_reg <= 1'b0;
                            state_reg    <= MULT;
                        end
                    end
                end
                MULT: begin
                    busy_reg <= 1'b1;
                    acc_reg  <= mul_sum[WIDTH:1];
                    q_reg    <= {mul_sum[0], q_reg[WIDTH-1:1]};
                    q_m1_reg <= q_reg[0];
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg <= FINISH;
                    end
                end
                DIV: begin
                    busy_reg <= 1'b1;
                    acc_reg  <= div_fits ? div_rem : div_shift[WIDTH-1:0];
                    q_reg    <= {q_reg[WIDTH-2:0], div_fits};
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                    if (zero_div_reg) begin
                        div_zero_reg <= 1'b1;
                    end else begin
                        hi_reg <= neg_r_reg ? ({WIDTH{1'b0}} - acc_reg) : acc_reg;
                        lo_reg <= neg_q_reg ? ({WIDTH{1'b0}} - q_reg) : q_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi_out   = hi_reg;
    assign bus.lo_out   = lo_reg;
endmodule

// File: tb/tb_mult_div_engine.sv
// Self-checking bench for mult_div_engine: directed cases plus randomized ops checked
// against a plain-arithmetic model of HI/LO, div-by-zero, latency and handshake.
module tb_mult_div_engine;
    localparam int W = 32;
`ifdef MULT_DIV_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    mult_div_engine_if #(.WIDTH(W)) bus_if ();
    mult_div_engine #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: whole-word arithmetic; signed division truncates toward zero.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
        logic uns;
        longint sp, sq, sr;
        logic [2*W-1:0] up;
        uns = UNS_EN && op[2];
        edz = 1'b0;
        eh = prev_hi;
        el = prev_lo;
        if (op[1:0] == 2'b01) begin
            if (uns) begin
                up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                eh = up[2*W-1:W];
                el = up[W-1:0];
            end else begin
                sp = longint'($signed(a)) * longint'($signed(b));
                eh = sp[2*W-1:W];
                el = sp[W-1:0];
            end
        end else if (b == '0) begin
            edz = 1'b1;
        end else if (uns) begin
            el = a / b;
            eh = a % b;
        end else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            el = sq[W-1:0];
            eh = sr[W-1:0];
        end
    endtask

    // Must be called at a negedge; returns at the negedge where done is seen.
    task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                            output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz,
                            output int lat, output int busy_cycles, output logic timed_out);
        bus_if.a_in = a;
        bus_if.b_in = b;
        bus_if.op = op;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a_in = $urandom;
        bus_if.b_in = $urandom;
        bus_if.op = 3'($urandom_range(0, 7));
        lat = 0;
        busy_cycles = 0;
        timed_out = 1'b1;
        hi = '0;
        lo = '0;
        dz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus_if.busy === 1'b1) busy_cycles++;
            if (bus_if.done === 1'b1) begin
                lat = k;
                hi = bus_if.hi_out;
                lo = bus_if.lo_out;
                dz = bus_if.div_zero;
                timed_out = 1'b0;
                break;
            end
        end
        $display("op=%b a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d", op, a, b, hi, lo, dz, lat, busy_cycles);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus_if.done); end
        checks++; if (bus_if.div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b want=0", bus_if.div_zero); end
        checks++; if (bus_if.hi_out !== '0) begin failures++; $display("FAIL reset_hi got=%h want=0", bus_if.hi_out); end
        checks++; if (bus_if.lo_out !== '0) begin failures++; $display("FAIL reset_lo got=%h want=0", bus_if.lo_out); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({bus_if.busy, bus_if.done} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b want=00", {bus_if.busy, bus_if.done}); end
        prev_hi = '0;
        prev_lo = '0;
    endtask

    task automatic test_mult_signed();
        logic [W-1:0] hi, lo;
        logic dz, to;
        int lat, bc;
        issue_op(32'd7, 32'hFFFF_FFFD, 3'b001, hi, lo, dz, lat, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL mult_timeout got=%b want=0", to); end
        checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency got=%0d want=33", lat); end
        checks++; if (bc != 32) begin failures++; $display("FAIL mult_busy_cycles got=%0d want=32", bc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL mult_dz got=%b want=0", dz); end
        prev_hi = 32'hFFFF_FFFF;
        prev_lo = 32'hFFFF_FFEB;
        @(negedge clk);
        checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL mult_done_width got=%b want=0", bus_if.done); end
    endtask

    task automatic test_div_signed();
        logic [W-1:0] hi, lo;
        logic dz, to;
        int lat, bc;
        issue_op(32'hFFFF_FFF9, 32'd2, 3'b010, hi, lo, dz, lat, bc, to);
        checks++; if (lat != 33 || to !== 1'b0) begin failures++; $display("FAIL div_latency got=%0d want=33", lat); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_dz got=%b want=0", dz); end
        @(negedge clk);
        issue_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b010, hi, lo, dz, lat, bc, to);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h want=0", hi); end
        checks++; if (dz !== 1'b0 || to !== 1'b0) begin failures++; $display("FAIL div_ovf_flags dz=%b to=%b want=0,0", dz, to); end
        prev_hi = 32'h0;
        prev_lo = 32'h8000_0000;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        logic [W-1:0] hi, lo;
        logic dz, to;
        int lat, bc;
        issue_op(32'd5, 32'd0, 3'b010, hi, lo, dz, lat, bc, to);
        checks++; if (lat != 1 || to !== 1'b0) begin failures++; $display("FAIL dz_latency got=%0d want=1", lat); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b want=1", dz); end
        checks++; if (bc != 0) begin failures++; $display("FAIL dz_busy got=%0d want=0", bc); end
        checks++; if (hi !== prev_hi || lo !== prev_lo) begin failures++; $display("FAIL dz_hold got=%h/%h want=%h/%h", hi, lo, prev_hi, prev_lo); end
        @(negedge clk);
        checks++; if ({bus_if.done, bus_if.div_zero, bus_if.busy} !== 3'b000) begin failures++; $display("FAIL dz_pulse_width got=%b want=000", {bus_if.done, bus_if.div_zero, bus_if.busy}); end
    endtask

    task automatic test_ignore_and_reset();
        logic [W-1:0] hi, lo;
        logic dz, to, found;
        int lat, bc, k_done;
        bus_if.a_in = 32'd3; bus_if.b_in = 32'd4; bus_if.op = 3'b001; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b want=1", bus_if.busy); end
        bus_if.a_in = 32'd9; bus_if.b_in = 32'd3; bus_if.op = 3'b010; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        found = 1'b0;
        k_done = 0;
        for (int k = 7; k <= 70; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin found = 1'b1; k_done = k; break; end
        end
        $display("op=001 a=3 b=4 (div ignored) -> hi=%h lo=%h lat=%0d", bus_if.hi_out, bus_if.lo_out, k_done);
        checks++; if (found !== 1'b1 || k_done != 33) begin failures++; $display("FAIL ign_latency got=%0d want=33", k_done); end
        checks++; if (bus_if.hi_out !== 32'd0 || bus_if.lo_out !== 32'd12) begin failures++; $display("FAIL ign_result got=%h/%h want=0/c", bus_if.hi_out, bus_if.lo_out); end
        bus_if.a_in = 32'd5; bus_if.b_in = 32'd6; bus_if.op = 3'b001; bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({bus_if.busy, bus_if.done, bus_if.div_zero} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b want=000", {bus_if.busy, bus_if.done, bus_if.div_zero}); end
        checks++; if (bus_if.hi_out !== '0 || bus_if.lo_out !== '0) begin failures++; $display("FAIL rst_mid_result got=%h/%h want=0/0", bus_if.hi_out, bus_if.lo_out); end
        prev_hi = '0;
        prev_lo = '0;
        issue_op(32'd2, 32'd2, 3'b001, hi, lo, dz, lat, bc, to);
        checks++; if (lat != 33 || to !== 1'b0) begin failures++; $display("FAIL rst_after_latency got=%0d want=33", lat); end
        checks++; if (hi !== 32'd0 || lo !== 32'd4) begin failures++; $display("FAIL rst_after_result got=%h/%h want=0/4", hi, lo); end
        prev_hi = 32'd0;
        prev_lo = 32'd4;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [W-1:0] hi, lo, want_hi;
        logic dz, to;
        int lat, bc;
        want_hi = UNS_EN ? 32'h0000_0001 : 32'hFFFF_FFFF;
        issue_op(32'hFFFF_FFFF, 32'd2, 3'b101, hi, lo, dz, lat, bc, to);
        checks++; if (lat != 33 || to !== 1'b0) begin failures++; $display("FAIL multu_latency got=%0d want=33", lat); end
        checks++; if (hi !== want_hi) begin failures++; $display("FAIL multu_hi got=%h want=%h", hi, want_hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
        prev_hi = want_hi;
        prev_lo = 32'hFFFF_FFFE;
        @(negedge clk);
    endtask

    // Each new op is issued in the very cycle done is high.
    task automatic test_back_to_back();
        logic [W-1:0] hi, lo, eh, el, a, b;
        logic dz, to, edz;
        int lat, bc;
        logic [2:0] ops [3];
        ops[0] = 3'b001; ops[1] = 3'b110; ops[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            model(a, b, ops[i], eh, el, edz);
            issue_op(a, b, ops[i], hi, lo, dz, lat, bc, to);
            checks++; if (lat != 33 || to !== 1'b0) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d want=33", i, lat); end
            checks++; if (hi !== eh || lo !== el || dz !== edz) begin failures++; $display("FAIL b2b_result[%0d] got=%h/%h/%b want=%h/%h/%b", i, hi, lo, dz, eh, el, edz); end
            prev_hi = eh;
            prev_lo = el;
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = W'($urandom_range(0, 20));
            3: v = -W'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [W-1:0] hi, lo, eh, el, a, b;
        logic dz, to, edz, bad;
        int lat, bc;
        logic [2:0] opc;
        logic [2:0] op_tab [10];
        op_tab = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b001, 3'b010, 3'b101, 3'b110, 3'b000, 3'b111};
        for (int i = 0; i < 24; i++) begin
            opc = op_tab[$urandom_range(0, 9)];
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
            if (opc[1:0] == 2'b00 || opc[1:0] == 2'b11) begin
                bus_if.a_in = a; bus_if.b_in = b; bus_if.op = opc; bus_if.start = 1'b1;
                @(negedge clk);
                bus_if.start = 1'b0;
                bad = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.div_zero !== 1'b0) bad = 1'b1;
                end
                $display("op=%b a=%h b=%h -> ignored hi=%h lo=%h", opc, a, b, bus_if.hi_out, bus_if.lo_out);
                checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rnd_invalid_op[%0d] op=%b got activity want none", i, opc); end
                checks++; if (bus_if.hi_out !== prev_hi || bus_if.lo_out !== prev_lo) begin failures++; $display("FAIL rnd_invalid_hold[%0d] got=%h/%h want=%h/%h", i, bus_if.hi_out, bus_if.lo_out, prev_hi, prev_lo); end
            end else begin
                model(a, b, opc, eh, el, edz);
                issue_op(a, b, opc, hi, lo, dz, lat, bc, to);
                checks++; if (to !== 1'b0 || lat != (edz ? 1 : 33) || bc != (edz ? 0 : 32)) begin failures++; $display("FAIL rnd_timing[%0d] got lat=%0d busy=%0d to=%b want lat=%0d", i, lat, bc, to, edz ? 1 : 33); end
                checks++; if (hi !== eh || lo !== el || dz !== edz) begin failures++; $display("FAIL rnd_result[%0d] op=%b a=%h b=%h got=%h/%h/%b want=%h/%h/%b", i, opc, a, b, hi, lo, dz, eh, el, edz); end
                prev_hi = eh;
                prev_lo = el;
                if ($urandom_range(0, 1) == 0) begin
                    @(negedge clk);
                    checks++; if (bus_if.done !== 1'b0 || bus_if.div_zero !== 1'b0) begin failures++; $display("FAIL rnd_pulse_width[%0d] got=%b%b want=00", i, bus_if.done, bus_if.div_zero); end
                end
            end
        end
    endtask

    initial begin
        bus_if.a_in = '0;
        bus_if.b_in = '0;
        bus_if.op = 3'b000;
        bus_if.start = 1'b0;
        test_reset();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_ignore_and_reset();
        test_unsigned();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
